// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, frame constants and baud divider helpers.
// Imported by receiver_uart, its interface and its sample-tick generator.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    RSTART,
    RDATA,
    RPARITY,
    RSTOP
  } rx_state_t;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      3'd0:    rate = 300;
      3'd1:    rate = 1200;
      3'd2:    rate = 4800;
      3'd3:    rate = 9600;
      3'd4:    rate = 19200;
      3'd5:    rate = 38400;
      3'd6:    rate = 57600;
      default: rate = 115200;
    endcase
    return rate;
  endfunction

  // Clocks per sample tick, rounded to nearest; clamped to 1 so slow clocks still tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned rate;
    int unsigned div;
    rate = baud_rate(sel);
    div  = (clk_hz + rate * (OVERSAMPLE / 32'd2)) / (rate * OVERSAMPLE);
    if (div == 32'd0) div = 32'd1;
    return div;
  endfunction

endpackage

// File: rtl/receiver_uart_if.sv
// receiver_uart_if: line-side inputs and received-byte outputs of receiver_uart.
// master = the receiver, slave = the consuming display/LED logic.
interface receiver_uart_if;
  import uart_pkg::*;

  logic [2:0]           baud_select;
  logic                 RX_EN;
  logic                 RxD;
  logic [DATA_BITS-1:0] Rx_DATA;
  logic                 Rx_VALID;
  logic                 Rx_PERROR;
  logic                 Rx_FERROR;

  modport master (
    input  baud_select,
    input  RX_EN,
    input  RxD,
    output Rx_DATA,
    output Rx_VALID,
    output Rx_PERROR,
    output Rx_FERROR
  );

  modport slave (
    output baud_select,
    output RX_EN,
    output RxD,
    input  Rx_DATA,
    input  Rx_VALID,
    input  Rx_PERROR,
    input  Rx_FERROR
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: one-clock sample-tick enable at OVERSAMPLE x the selected baud rate.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       tick
);

  // The slowest rate needs the largest divider, so it sizes the counter.
  localparam int unsigned MAX_DIV = calc_div(CLK_HZ, 3'd0);
  localparam int          DIV_W   = $clog2(MAX_DIV + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic [2:0]       baud_q;

  assign div_last = DIV_W'(calc_div(CLK_HZ, baud_select) - 32'd1);

  // A rate change restarts the divider so the new rate begins from a clean period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      baud_q  <= '0;
      tick    <= 1'b0;
    end else if (baud_select != baud_q) begin
      baud_q  <= baud_select;
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == div_last) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/receiver_uart.sv
// receiver_uart: 16x-oversampled UART receiver for 8E1 frames, byte plus parity/framing status out.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at counts 7/8/9 (default: single sample at 7).
module receiver_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic            clk,
  input  logic            reset,
  receiver_uart_if.master bus
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 32'd1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 32'd1);

  rx_state_t            state;
  logic                 tick;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 bit_val;
  logic                 at_eval;
  logic                 at_end;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;

  uart_rx_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .baud_select (bus.baud_select),
    .tick        (tick)
  );

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.RxD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] EVAL_CNT = CNT_W'(9);

  logic samp7;
  logic samp8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp7 <= 1'b1;
      samp8 <= 1'b1;
    end else if (tick) begin
      if (cnt == CNT_W'(7)) samp7 <= rx_sync;
      if (cnt == CNT_W'(8)) samp8 <= rx_sync;
    end
  end

  assign bit_val = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);
`else
  localparam logic [CNT_W-1:0] EVAL_CNT = CNT_W'(7);

  assign bit_val = rx_sync;
`endif

  assign at_eval = tick && (cnt == EVAL_CNT);
  assign at_end  = tick && (cnt == CNT_LAST);

  // Stop is evaluated mid-bit and the FSM returns to IDLE at once, so back-to-back frames resync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) cnt <= cnt + 1'b1;

      if (!bus.RX_EN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state <= RSTART;
              cnt   <= '0;
            end
          end
          RSTART: begin
            if (at_eval && bit_val) begin
              state <= IDLE;
            end else if (at_end) begin
              state   <= RDATA;
              bit_idx <= '0;
            end
          end
          RDATA: begin
            if (at_eval) shift[bit_idx] <= bit_val;
            if (at_end) begin
              if (bit_idx == IDX_LAST) state <= RPARITY;
              else                     bit_idx <= bit_idx + 1'b1;
            end
          end
          RPARITY: begin
            if (at_eval) parity_bit <= bit_val;
            if (at_end)  state      <= RSTOP;
          end
          RSTOP: begin
            if (at_eval) begin
              data_q  <= shift;
              perr_q  <= (^shift) ^ parity_bit;
              ferr_q  <= ~bit_val;
              valid_q <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Rx_DATA   = data_q;
  assign bus.Rx_VALID  = valid_q;
  assign bus.Rx_PERROR = perr_q;
  assign bus.Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_receiver_uart.sv
// tb_receiver_uart: directed bench for receiver_uart; a frame queue predicts every completion and
// the held outputs, and literal expectations pin the results of each scenario.
module tb_receiver_uart;

  // Slow system clock keeps 300-baud frames short: DIV is 128 at 300, 4 at 9600, 1 at 115200.
  localparam int CLK_HZ = 614_400;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic clk;
  logic reset;

  receiver_uart_if bus_if ();

  receiver_uart #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  frame_t     exp_q[$];
  logic [7:0] held_data  = 8'h00;
  logic       held_perr  = 1'b0;
  logic       held_ferr  = 1'b0;
  int         check_count = 0;
  int         pass_count  = 0;
  int         valid_seen  = 0;
  int         bit_clocks  = 16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    check_count++;
    if (actual === required) pass_count++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
  endtask

  function automatic int bit_time(input logic [2:0] sel);
    int rates [8];
    int div;
    rates = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    div = (CLK_HZ + 8 * rates[sel]) / (16 * rates[sel]);
    if (div < 1) div = 1;
    return 16 * div;
  endfunction

  task automatic set_baud(input logic [2:0] sel);
    bus_if.baud_select = sel;
    bit_clocks = bit_time(sel);
    repeat (4) @(negedge clk);
  endtask

  task automatic line_level(input logic level, input int clocks);
    bus_if.RxD = level;
    repeat (clocks) @(negedge clk);
  endtask

  // Drives the first nbits of a frame; a recorded frame is what the receiver must report.
  task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stp,
                                input int nbits, input bit record);
    logic [10:0] bits;
    frame_t      f;
    bits = {stp, par, data, 1'b0};
    if (record) begin
      f.data = data;
      f.perr = ($countones({data, par}) % 2) != 0;
      f.ferr = !stp;
      exp_q.push_back(f);
    end
    for (int i = 0; i < nbits; i++) line_level(bits[i], bit_clocks);
  endtask

  task automatic check_frame(input string name, input logic [7:0] data, input logic perr,
                             input logic ferr, input int total_valid);
    check_output({name, "_data"},  32'(bus_if.Rx_DATA),   32'(data));
    check_output({name, "_perr"},  32'(bus_if.Rx_PERROR), 32'(perr));
    check_output({name, "_ferr"},  32'(bus_if.Rx_FERROR), 32'(ferr));
    check_output({name, "_valids"}, 32'(valid_seen),      32'(total_valid));
  endtask

  // Every cycle: a completion must match the head of the queue; otherwise outputs hold.
  initial begin : compare
    frame_t f;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.Rx_VALID === 1'b1) begin
        valid_seen++;
        check_output("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          f         = exp_q.pop_front();
          held_data = f.data;
          held_perr = f.perr;
          held_ferr = f.ferr;
        end
      end else begin
        check_output("valid_low", 32'(bus_if.Rx_VALID), 32'd0);
      end
      check_output("rx_data",   32'(bus_if.Rx_DATA),   32'(held_data));
      check_output("rx_perror", 32'(bus_if.Rx_PERROR), 32'(held_perr));
      check_output("rx_ferror", 32'(bus_if.Rx_FERROR), 32'(held_ferr));
    end
  end

  initial begin : stimulus
    reset              = 1'b1;
    bus_if.RX_EN       = 1'b1;
    bus_if.RxD         = 1'b1;
    bus_if.baud_select = 3'd7;
    repeat (3) @(negedge clk);
    check_frame("reset", 8'h00, 1'b0, 1'b0, 0);
    check_output("reset_valid", 32'(bus_if.Rx_VALID), 32'd0);
    reset = 1'b0;

    set_baud(3'd7);
    line_level(1'b1, 2 * bit_clocks);

    apply_stimulus(8'hA5, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("clean", 8'hA5, 1'b0, 1'b0, 1);

    apply_stimulus(8'hA5, 1'b1, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("parity", 8'hA5, 1'b1, 1'b0, 2);

    // Reset mid-data: start bit plus three data bits, then clear everything at once.
    apply_stimulus(8'h96, 1'b0, 1'b1, 4, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    held_data = 8'h00;
    held_perr = 1'b0;
    held_ferr = 1'b0;
    #1;
    check_frame("mid_reset", 8'h00, 1'b0, 1'b0, 2);
    @(negedge clk);
    bus_if.RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    line_level(1'b1, 2 * bit_clocks);

    apply_stimulus(8'h3C, 1'b0, 1'b0, 11, 1'b1);
    line_level(1'b0, 2 * bit_clocks);
    check_frame("framing", 8'h3C, 1'b0, 1'b1, 3);
    line_level(1'b1, bit_clocks);
    apply_stimulus(8'h81, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("after_break", 8'h81, 1'b0, 1'b0, 4);

    set_baud(3'd3);
    line_level(1'b1, bit_clocks);
    line_level(1'b0, 3 * (bit_clocks / 16));
    line_level(1'b1, 2 * bit_clocks);
    check_output("glitch_valids", 32'(valid_seen), 32'd4);
    apply_stimulus(8'h55, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("after_glitch", 8'h55, 1'b0, 1'b0, 5);

    set_baud(3'd0);
    line_level(1'b1, bit_clocks);
    apply_stimulus(8'h00, 1'b0, 1'b1, 11, 1'b1);
    apply_stimulus(8'hFF, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("b2b_300", 8'hFF, 1'b0, 1'b0, 7);

    set_baud(3'd7);
    line_level(1'b1, bit_clocks);
    apply_stimulus(8'h00, 1'b0, 1'b1, 11, 1'b1);
    apply_stimulus(8'hFF, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("b2b_115200", 8'hFF, 1'b0, 1'b0, 9);

    // Enable dropped mid-frame: nothing completes and the last byte stays put.
    apply_stimulus(8'h0F, 1'b0, 1'b1, 5, 1'b0);
    bus_if.RX_EN = 1'b0;
    line_level(1'b1, 2 * bit_clocks);
    check_frame("rx_en_drop", 8'hFF, 1'b0, 1'b0, 9);
    bus_if.RX_EN = 1'b1;
    line_level(1'b1, bit_clocks);
    apply_stimulus(8'h5A, 1'b0, 1'b1, 11, 1'b1);
    line_level(1'b1, 2 * bit_clocks);
    check_frame("after_drop", 8'h5A, 1'b0, 1'b0, 10);

    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
